// File: rtl/fm_pkg.sv
// Shared constants and FSM state type for the FM parameter SPI slave.
package fm_pkg;

    // Frame layout: 1 R/W bit + 7 address bits, then 32 data bits.
    localparam int FRAME_BITS = 40;
    localparam int ADDR_BITS  = 8;

    // Register address map.
    localparam logic [6:0] ADDR_CARRIER = 7'h00;
    localparam logic [6:0] ADDR_MOD     = 7'h01;
    localparam logic [6:0] ADDR_DEV     = 7'h02;
    localparam logic [6:0] ADDR_CTRL    = 7'h03;
    localparam logic [6:0] ADDR_COMMIT  = 7'h04;

    // Frame-receive FSM states; encoding is visible on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } spi_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a third flop for single-cycle rise/fall pulses.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    // Shift the asynchronous input through the synchronizer and history stage.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Synchronizer registers; reset to the line's idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
            s3_q <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q;
    assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/fm_param_spi.sv
// SPI-slave shadow/active parameter bank feeding the FM generator.
// Writes land in shadow registers; a COMMIT write copies all shadows to the
// active outputs in a single cycle so the generator never sees a partial set.
module fm_param_spi
    import fm_pkg::*;
#(
    parameter int ACC_WIDTH   = 32,
    parameter int SINE_WIDTH  = 16,
    parameter int CARRIER_RST = 200000000,
    parameter int MOD_RST     = 66770,
    parameter int DEV_RST     = 4
) (
    input  logic                  i_clk,
    input  logic                  i_resetb,
    input  logic                  i_sclk,
    input  logic                  i_cs_n,
    input  logic                  i_mosi,
    output logic                  o_miso,
    output logic [ACC_WIDTH-2:0]  o_carrier_inc,
    output logic [ACC_WIDTH-2:0]  o_mod_inc,
    output logic [SINE_WIDTH:0]   o_deviation,
    output logic                  o_ce,
    output logic                  o_update,
    output logic                  o_frame_err,
    output logic [1:0]            o_dbg_state
);

    localparam int CAR_W = ACC_WIDTH - 1;
    localparam int DEV_W = SINE_WIDTH + 1;
    localparam logic [CAR_W-1:0] CAR_INIT = CAR_W'(CARRIER_RST);
    localparam logic [CAR_W-1:0] MOD_INIT = CAR_W'(MOD_RST);
    localparam logic [DEV_W-1:0] DEV_INIT = DEV_W'(DEV_RST);
    localparam logic [5:0] LAST_HDR_BIT   = 6'(ADDR_BITS - 1);
    localparam logic [5:0] LAST_FRAME_BIT = 6'(FRAME_BITS - 1);

    logic sclk_rise, sclk_fall, unused_sclk_lvl;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, unused_mosi_rise, unused_mosi_fall;

    sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(i_clk), .rst_n(i_resetb), .d(i_sclk),
        .level(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    // Chip select idles high, so its synchronizer resets high to avoid a false frame start.
    sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(i_clk), .rst_n(i_resetb), .d(i_cs_n),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(i_clk), .rst_n(i_resetb), .d(i_mosi),
        .level(mosi_lvl), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    spi_state_e state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic [31:0]           tx_q, tx_d;
    logic                  miso_q, miso_d;
    logic [CAR_W-1:0]      car_sh_q, car_sh_d, mod_sh_q, mod_sh_d;
    logic [DEV_W-1:0]      dev_sh_q, dev_sh_d;
    logic                  ce_sh_q, ce_sh_d;
    logic [CAR_W-1:0]      car_q, car_d, mod_q, mod_d;
    logic [DEV_W-1:0]      dev_q, dev_d;
    logic                  ce_q, ce_d;
    logic                  upd_q, upd_d, err_q, err_d;

    logic [6:0]  rd_addr;
    logic [31:0] rd_val;
    logic [6:0]  wr_addr;

    // The address completes on the 8th SCLK edge: 6 bits already shifted plus the live MOSI bit.
    assign rd_addr = {rx_q[5:0], mosi_lvl};
    assign wr_addr = rx_q[FRAME_BITS-2:32];

    // Read-back mux: shadow value zero-extended; COMMIT and unmapped read 0.
    always_comb begin
        rd_val = '0;
        case (rd_addr)
            ADDR_CARRIER: rd_val = 32'(car_sh_q);
            ADDR_MOD:     rd_val = 32'(mod_sh_q);
            ADDR_DEV:     rd_val = 32'(dev_sh_q);
            ADDR_CTRL:    rd_val = 32'(ce_sh_q);
            default:      rd_val = '0;
        endcase
    end

    // Frame FSM, shift registers, shadow writes and commit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        miso_d   = miso_q;
        car_sh_d = car_sh_q;
        mod_sh_d = mod_sh_q;
        dev_sh_d = dev_sh_q;
        ce_sh_d  = ce_sh_q;
        car_d    = car_q;
        mod_d    = mod_q;
        dev_d    = dev_q;
        ce_d     = ce_q;
        upd_d    = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d = ST_ADDR;
                    cnt_d   = '0;
                end
            end
            ST_ADDR: begin
                if (cs_rise) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end else if (sclk_rise) begin
                    rx_d  = {rx_q[FRAME_BITS-2:0], mosi_lvl};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST_HDR_BIT) begin
                        state_d = ST_DATA;
                        // rx_q[6] holds the R/W bit at this point.
                        tx_d    = rx_q[ADDR_BITS-2] ? rd_val : '0;
                    end
                end
            end
            ST_DATA: begin
                if (cs_rise) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end else if (sclk_rise) begin
                    rx_d  = {rx_q[FRAME_BITS-2:0], mosi_lvl};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST_FRAME_BIT) begin
                        state_d = ST_DONE;
                    end
                end else if (sclk_fall) begin
                    miso_d = tx_q[31];
                    tx_d   = {tx_q[30:0], 1'b0};
                end
            end
            ST_DONE: begin
                if (sclk_rise) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end else if (cs_rise) begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                    if (!rx_q[FRAME_BITS-1]) begin
                        case (wr_addr)
                            ADDR_CARRIER: car_sh_d = rx_q[CAR_W-1:0];
                            ADDR_MOD:     mod_sh_d = rx_q[CAR_W-1:0];
                            ADDR_DEV:     dev_sh_d = rx_q[DEV_W-1:0];
                            ADDR_CTRL:    ce_sh_d  = rx_q[0];
                            ADDR_COMMIT: begin
                                car_d = car_sh_q;
                                mod_d = mod_sh_q;
                                dev_d = dev_sh_q;
                                ce_d  = ce_sh_q;
                                upd_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end else if (sclk_fall) begin
                    miso_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, shadow and active registers.
    always_ff @(posedge i_clk or negedge i_resetb) begin
        if (!i_resetb) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
            miso_q   <= 1'b0;
            car_sh_q <= CAR_INIT;
            mod_sh_q <= MOD_INIT;
            dev_sh_q <= DEV_INIT;
            ce_sh_q  <= 1'b1;
            car_q    <= CAR_INIT;
            mod_q    <= MOD_INIT;
            dev_q    <= DEV_INIT;
            ce_q     <= 1'b1;
            upd_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            miso_q   <= miso_d;
            car_sh_q <= car_sh_d;
            mod_sh_q <= mod_sh_d;
            dev_sh_q <= dev_sh_d;
            ce_sh_q  <= ce_sh_d;
            car_q    <= car_d;
            mod_q    <= mod_d;
            dev_q    <= dev_d;
            ce_q     <= ce_d;
            upd_q    <= upd_d;
            err_q    <= err_d;
        end
    end

    assign o_miso        = miso_q & ~cs_lvl;
    assign o_carrier_inc = car_q;
    assign o_mod_inc     = mod_q;
    assign o_deviation   = dev_q;
    assign o_ce          = ce_q;
    assign o_update      = upd_q;
    assign o_frame_err   = err_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_fm_param_spi.sv
// Self-checking bench for fm_param_spi: SPI frames driven at pin level.
module tb_fm_param_spi;
  import fm_pkg::*;

  localparam int HALF = 8;  // SCLK half period in i_clk cycles

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        o_miso;
  logic [30:0] o_carrier_inc;
  logic [30:0] o_mod_inc;
  logic [16:0] o_deviation;
  logic        o_ce;
  logic        o_update;
  logic        o_frame_err;
  logic [1:0]  o_dbg_state;

  fm_param_spi dut (
    .i_clk(clk), .i_resetb(resetb), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
    .o_miso(o_miso), .o_carrier_inc(o_carrier_inc), .o_mod_inc(o_mod_inc),
    .o_deviation(o_deviation), .o_ce(o_ce), .o_update(o_update),
    .o_frame_err(o_frame_err), .o_dbg_state(o_dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  int err_seen = 0;

  always @(negedge clk) begin
    if (o_frame_err) err_seen++;
  end

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver: clock nbits of a frame out, capturing MISO just before each rising SCLK
  task automatic spi_bits(input logic [39:0] frame, input int nbits,
                          output logic [31:0] rd, output logic hdr_miso);
    rd = '0;
    hdr_miso = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 40) ? frame[39-i] : 1'b0;
      wait_clk(HALF);
      if (i < 8) hdr_miso = hdr_miso | o_miso;
      else if (i < 40) rd[39-i] = o_miso;
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  // driver: full chip-select framed transfer; returns right after CS_n rises
  task automatic spi_frame(input logic [39:0] frame, input int nbits,
                           output logic [31:0] rd, output logic hdr_miso);
    cs_n = 1'b0;
    wait_clk(HALF);
    spi_bits(frame, nbits, rd, hdr_miso);
    wait_clk(HALF);
    cs_n = 1'b1;
  endtask

  // watch 12 cycles after CS_n rises: pulse counts, first-pulse cycle, carrier around update
  task automatic settle(output int uc, output int ui, output int ec, output int ei,
                        output logic [30:0] pre, output logic [30:0] post);
    logic [30:0] prev;
    uc = 0; ui = 0; ec = 0; ei = 0;
    prev = o_carrier_inc;
    pre = prev;
    post = prev;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (o_update) begin
        uc++;
        if (ui == 0) begin
          ui = c;
          pre = prev;
          post = o_carrier_inc;
        end
      end
      if (o_frame_err) begin
        ec++;
        if (ei == 0) ei = c;
      end
      prev = o_carrier_inc;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        hdr;
    int uc, ui, ec, ei, err_before;
    logic [30:0] pre, post;

    vecs[0] = '{7'h00, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    vecs[1] = '{7'h01, 32'h1234_5678, 32'h1234_5678};
    vecs[2] = '{7'h02, 32'hFFFF_FFFF, 32'h0001_FFFF};
    vecs[3] = '{7'h03, 32'hFFFF_FFFE, 32'h0000_0000};
    vecs[4] = '{7'h03, 32'h0000_0003, 32'h0000_0001};
    vecs[5] = '{7'h05, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[6] = '{7'h7F, 32'h0000_0055, 32'h0000_0000};
    vecs[7] = '{7'h00, 32'd50000000,  32'd50000000};

    // reset state
    wait_clk(5);
    check("rst_carrier", o_carrier_inc, 32'd200000000);
    check("rst_mod", o_mod_inc, 32'd66770);
    check("rst_dev", o_deviation, 32'd4);
    check("rst_ce", o_ce, 32'd1);
    check("rst_update", o_update, 32'd0);
    check("rst_frame_err", o_frame_err, 32'd0);
    check("rst_miso", o_miso, 32'd0);
    check("rst_state", o_dbg_state, ST_IDLE);
    resetb = 1'b1;
    wait_clk(5);

    // table: write each vector, confirm active outputs untouched, read it back
    for (int v = 0; v < 8; v++) begin
      spi_frame({1'b0, vecs[v].addr, vecs[v].wdata}, 40, rd, hdr);
      settle(uc, ui, ec, ei, pre, post);
      check($sformatf("wr%0d_update", v), uc, 0);
      check($sformatf("wr%0d_err", v), ec, 0);
      check($sformatf("wr%0d_active_carrier", v), o_carrier_inc, 32'd200000000);
      check($sformatf("wr%0d_active_mod", v), o_mod_inc, 32'd66770);
      exp_q.push_back(vecs[v].rexp);
      spi_frame({1'b1, vecs[v].addr, 32'h0}, 40, rd, hdr);
      settle(uc, ui, ec, ei, pre, post);
      check($sformatf("rd%0d_data", v), rd, exp_q.pop_front());
      check($sformatf("rd%0d_hdr_miso", v), hdr, 32'd0);
      check($sformatf("rd%0d_miso_idle", v), o_miso, 32'd0);
    end

    // read of the COMMIT address returns 0 and does not commit
    exp_q.push_back(32'h0);
    spi_frame({1'b1, ADDR_COMMIT, 32'hFFFF_FFFF}, 40, rd, hdr);
    settle(uc, ui, ec, ei, pre, post);
    check("rd_commit_data", rd, exp_q.pop_front());
    check("rd_commit_update", uc, 0);

    // commit: one update pulse 3 cycles after CS_n rises, outputs change in that cycle
    spi_frame({1'b0, ADDR_COMMIT, 32'hA5A5_A5A5}, 40, rd, hdr);
    settle(uc, ui, ec, ei, pre, post);
    check("commit_update_count", uc, 1);
    check("commit_update_cycle", ui, 3);
    check("commit_carrier_before", pre, 32'd200000000);
    check("commit_carrier_at_update", post, 32'd50000000);
    check("commit_carrier", o_carrier_inc, 32'd50000000);
    check("commit_mod", o_mod_inc, 32'h1234_5678);
    check("commit_dev", o_deviation, 32'h0001_FFFF);
    check("commit_ce", o_ce, 32'd1);

    // short frame: 20 bits then CS_n high
    spi_frame({1'b0, ADDR_CARRIER, 32'h1111_1111}, 20, rd, hdr);
    settle(uc, ui, ec, ei, pre, post);
    check("short_err_count", ec, 1);
    check("short_err_cycle", ei, 3);
    check("short_update", uc, 0);
    check("short_state", o_dbg_state, ST_IDLE);
    exp_q.push_back(32'd50000000);
    spi_frame({1'b1, ADDR_CARRIER, 32'h0}, 40, rd, hdr);
    settle(uc, ui, ec, ei, pre, post);
    check("short_next_read", rd, exp_q.pop_front());
    check("short_next_err", ec, 0);

    // long frame: 41 SCLK edges to the carrier shadow
    err_before = err_seen;
    spi_frame({1'b0, ADDR_CARRIER, 32'h2222_2222}, 41, rd, hdr);
    settle(uc, ui, ec, ei, pre, post);
    check("long_err_total", err_seen - err_before, 1);
    check("long_err_after_cs", ec, 0);
    check("long_state", o_dbg_state, ST_IDLE);
    exp_q.push_back(32'd50000000);
    spi_frame({1'b1, ADDR_CARRIER, 32'h0}, 40, rd, hdr);
    settle(uc, ui, ec, ei, pre, post);
    check("long_shadow_read", rd, exp_q.pop_front());
    check("long_active_carrier", o_carrier_inc, 32'd50000000);

    // reset after 30 bits of a write to the modulation shadow
    cs_n = 1'b0;
    wait_clk(HALF);
    spi_bits({1'b0, ADDR_MOD, 32'h0BAD_BEEF}, 30, rd, hdr);
    resetb = 1'b0;
    wait_clk(2);
    check("midrst_state", o_dbg_state, ST_IDLE);
    check("midrst_carrier", o_carrier_inc, 32'd200000000);
    check("midrst_mod", o_mod_inc, 32'd66770);
    check("midrst_dev", o_deviation, 32'd4);
    check("midrst_miso", o_miso, 32'd0);
    cs_n = 1'b1;
    wait_clk(4);
    resetb = 1'b1;
    wait_clk(8);
    spi_frame({1'b0, ADDR_COMMIT, 32'h0}, 40, rd, hdr);
    settle(uc, ui, ec, ei, pre, post);
    check("midrst_commit_update", uc, 1);
    check("midrst_commit_mod", o_mod_inc, 32'd66770);
    check("midrst_commit_carrier", o_carrier_inc, 32'd200000000);
    check("midrst_commit_err", ec, 0);
    check("midrst_end_state", o_dbg_state, ST_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fm_param_spi.md
# fm_param_spi

SPI-slave parameter block that sits directly upstream of the FM generator and replaces its hard-wired constants (carrier center increment, modulation increment, deviation, clock-enable). An external controller writes shadow registers over a 4-wire SPI link. A commit write then copies all shadows to the active outputs in one cycle and pulses `o_update`, so the generator never sees a half-updated parameter set. The block runs in the PLL output clock domain that feeds the generator.

## Interface
Parameters:
- `ACC_WIDTH`, 32, generator accumulator width; increment outputs are `ACC_WIDTH-1` bits.
- `SINE_WIDTH`, 16, sine lookup width; deviation output is `SINE_WIDTH+1` bits.
- `CARRIER_RST`, 200000000, reset value of carrier increment.
- `MOD_RST`, 66770, reset value of modulation increment.
- `DEV_RST`, 4, reset value of deviation.

Ports:
- `i_clk`  in  1  generator clock (PLL output); all logic is on its rising edge.
- `i_resetb`  in  1  reset; one clock, reset is asynchronous and active-low.
- `i_sclk`  in  1  SPI clock, asynchronous to `i_clk`, mode 0.
- `i_cs_n`  in  1  SPI chip select, active low.
- `i_mosi`  in  1  SPI data in.
- `o_miso`  out  1  SPI data out (read-back).
- `o_carrier_inc`  out  ACC_WIDTH-1  active carrier center increment.
- `o_mod_inc`  out  ACC_WIDTH-1  active modulation increment.
- `o_deviation`  out  SINE_WIDTH+1  active modulation deviation amount.
- `o_ce`  out  1  active generator clock-enable.
- `o_update`  out  1  one-cycle pulse when active outputs change.
- `o_frame_err`  out  1  one-cycle pulse on a discarded frame.

## Operation
- SCLK, CS_n and MOSI pass through 2-FF synchronizers, then edge detection. MOSI is sampled on the synced SCLK rising edge. MISO changes on the synced SCLK falling edge.
- Frame: 40 bits, MSB first.
  - bit39: R/W (1 = read).
  - bits38:32: 7-bit address.
  - bits31:0: data.
- Address map:
  - 0x00: carrier shadow.
  - 0x01: modulation shadow.
  - 0x02: deviation shadow.
  - 0x03: ce shadow (bit0).
  - 0x04: COMMIT. A write with any data copies all shadows to the active outputs.
- Write field rules: data bits above the field width are ignored.
- Read rules: read returns the shadow value, zero-extended to 32 bits. COMMIT and unmapped addresses read 0.
- FSM:
  - IDLE → ADDR on the synced CS_n falling edge; bit counter cleared.
  - ADDR → DATA after 8 bits. On a read, the shadow value is latched into the MISO shift register here.
  - DATA → DONE after 32 bits.
  - DONE → IDLE on the synced CS_n rising edge. A write is applied at that point.
  - CS_n rising in ADDR or DATA (short frame), or a 41st SCLK edge in DONE (long frame): discard the frame, pulse `o_frame_err`, go to IDLE. Shadows are unchanged.
- Writes to unmapped addresses (0x05–0x7F) are accepted and ignored; no error.
- Reset values:
  - Shadow and active outputs = `CARRIER_RST` / `MOD_RST` / `DEV_RST`, ce = 1.
  - `o_update` = 0, `o_frame_err` = 0, `o_miso` = 0, FSM in IDLE.
- Reset mid-frame: the frame is lost, everything returns to reset values, and the synchronizers clear.
- `o_miso` is 0 during ADDR, and is 0 in IDLE or whenever CS_n is high.

## Timing
- SCLK frequency must be ≤ `i_clk`/8. SCLK high and low times must each be ≥ 4 `i_clk` cycles.
- Shadow write: the shadow register changes 3 `i_clk` cycles after the pin-level CS_n rising edge (2 sync + 1 edge-detect/apply).
- COMMIT: the active outputs change and `o_update` is high in the same cycle, 3 cycles after the pin-level CS_n rising edge. `o_update` is high for exactly 1 cycle.
- Active outputs are registered. They are stable at all times except the commit cycle.
- `o_frame_err` is high for 1 cycle, in the cycle the discard is decided.
- Back-to-back frames need CS_n high for ≥ 4 `i_clk` cycles.

## Structure
- Package `fm_pkg` holds:
  - address constants `ADDR_CARRIER`, `ADDR_MOD`, `ADDR_DEV`, `ADDR_CTRL`, `ADDR_COMMIT`;
  - `FRAME_BITS` = 40, `ADDR_BITS` = 8;
  - the FSM state enum.
- One sub-module, `sync_edge`: 2-FF synchronizer plus rise/fall pulse outputs, instantiated three times (SCLK, CS_n, MOSI; MOSI uses level only).
- Shadow and active register banks and the FSM live in the top.

## Test plan
- Reset: assert `i_resetb` = 0. Required: `o_carrier_inc` = 200000000, `o_mod_inc` = 66770, `o_deviation` = 4, `o_ce` = 1, `o_update` = 0.
- Write then commit:
  - Write 0x00 = 50000000. Required: outputs unchanged.
  - Write 0x04. Required: `o_carrier_inc` = 50000000, with a single `o_update` pulse in the same cycle.
- Read-back:
  - Write 0x02 = 0xFFFF_FFFF, then read 0x02. Required: MISO returns 0x0001FFFF (17-bit field).
  - Read 0x05. Required: 0.
- Short frame: 20 bits then CS_n high. Required: one `o_frame_err` pulse, shadows unchanged, and the next valid frame is accepted.
- Long frame: 41 bits to 0x00. Required: `o_frame_err` pulse and no shadow change.
- Reset mid-frame: assert `i_resetb` low after 30 bits of a write to 0x01. Required: `o_mod_inc` stays 66770 after the subsequent commit, and the FSM returns to IDLE.
